// File: rtl/project1_pkg.sv
// Shared types, choice encodings and denomination table for the project1 payment controller.
package project1_pkg;

  localparam int          W       = 16;
  localparam logic [15:0] MAX_AMT = 16'hFFFF;

  localparam logic [1:0] CH_IDLE   = 2'b00;
  localparam logic [1:0] CH_DD     = 2'b01;
  localparam logic [1:0] CH_CASH   = 2'b10;
  localparam logic [1:0] CH_SETTLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_SETTLE  = 2'b10
  } state_e;

  // The largest note (2000) fits in 12 bits; callers zero-extend to their bus width.
  typedef struct packed {
    logic        vld;
    logic [11:0] val;
  } denom_t;

  function automatic denom_t denom_lookup(input logic [3:0] code);
    denom_t d;
    d.vld = 1'b1;
    case (code)
      4'd1:    d.val = 12'd1;
      4'd2:    d.val = 12'd2;
      4'd3:    d.val = 12'd5;
      4'd4:    d.val = 12'd10;
      4'd5:    d.val = 12'd20;
      4'd6:    d.val = 12'd50;
      4'd7:    d.val = 12'd100;
      4'd8:    d.val = 12'd200;
      4'd9:    d.val = 12'd500;
      4'd10:   d.val = 12'd2000;
      default: begin
        d.vld = 1'b0;
        d.val = 12'd0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/project1_sat_add.sv
// Unsigned W-bit adder that clamps at a ceiling instead of wrapping.
module project1_sat_add #(
  parameter int         W   = 16,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = (w_full > {1'b0, MAX}) ? MAX : w_full[W-1:0];

endmodule

// File: rtl/project1_payment_ctrl.sv
// Kiosk payment controller: collects one DD per DD_IN assertion plus cash notes,
// then settles against the amount due, pulsing dis for one cycle on success.
module project1_payment_ctrl
  import project1_pkg::*;
#(
  parameter int           W       = project1_pkg::W,
  parameter logic [W-1:0] MAX_AMT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   choice,
  input  logic [W-1:0] paymentAmount,
  input  logic [W-1:0] ddamt,
  input  logic [3:0]   currency,
  output logic [W-1:0] paidamt,
  output logic [W-1:0] totalcurrency,
  output logic [W-1:0] storedExcessAmount,
  output logic [W-1:0] storedInsufficientAmount,
  output logic         successful,
  output logic         dis
);

  state_e       r_state;
  logic         r_dd_taken;
  logic [3:0]   r_prev_cur;
  logic [W-1:0] r_paid;
  logic [W-1:0] r_cash;
  logic [W-1:0] r_excess;
  logic [W-1:0] r_insuf;
  logic         r_success;
  logic         r_dis;

  denom_t       w_note;
  logic [W-1:0] w_note_val;
  logic         w_dd_acc;
  logic         w_cash_acc;
  logic         w_acc;
  logic [W-1:0] w_contrib;
  logic [W-1:0] w_paid_base;
  logic [W-1:0] w_cash_base;
  logic [W-1:0] w_paid_nxt;
  logic [W-1:0] w_cash_nxt;

  assign w_note     = denom_lookup(currency);
  assign w_note_val = {{(W-12){1'b0}}, w_note.val};

  // Nothing is accepted during the single settle cycle.
  assign w_dd_acc   = (r_state != ST_SETTLE) && (choice == CH_DD) &&
                      (ddamt != '0) && !r_dd_taken;
  assign w_cash_acc = (r_state != ST_SETTLE) && (choice == CH_CASH) &&
                      (currency != 4'd0) && (r_prev_cur == 4'd0) && w_note.vld;
  assign w_acc      = w_dd_acc || w_cash_acc;
  assign w_contrib  = w_dd_acc ? ddamt : (w_cash_acc ? w_note_val : '0);

  // A transaction start loads the contribution rather than accumulating onto stale totals.
  assign w_paid_base = (r_state == ST_IDLE) ? '0 : r_paid;
  assign w_cash_base = (r_state == ST_IDLE) ? '0 : r_cash;

  project1_sat_add #(.W(W), .MAX(MAX_AMT)) u_paid_add (
    .i_a   (w_paid_base),
    .i_b   (w_contrib),
    .o_sum (w_paid_nxt)
  );

  project1_sat_add #(.W(W), .MAX(MAX_AMT)) u_cash_add (
    .i_a   (w_cash_base),
    .i_b   (w_cash_acc ? w_note_val : '0),
    .o_sum (w_cash_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_dd_taken <= 1'b0;
      r_prev_cur <= 4'd0;
      r_paid     <= '0;
      r_cash     <= '0;
      r_excess   <= '0;
      r_insuf    <= '0;
      r_success  <= 1'b0;
      r_dis      <= 1'b0;
    end else begin
      r_prev_cur <= currency;
      r_dd_taken <= (choice == CH_DD) && (r_dd_taken || w_dd_acc);
      r_dis      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_paid    <= w_paid_nxt;
            r_cash    <= w_cash_nxt;
            r_success <= 1'b0;
            r_excess  <= '0;
            r_insuf   <= '0;
            r_state   <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (choice == CH_SETTLE) begin
            if (r_paid >= paymentAmount) begin
              r_success <= 1'b1;
              r_dis     <= 1'b1;
              r_excess  <= r_paid - paymentAmount;
              r_insuf   <= '0;
            end else begin
              r_success <= 1'b0;
              r_excess  <= '0;
              r_insuf   <= paymentAmount - r_paid;
            end
            r_state <= ST_SETTLE;
          end else if (w_acc) begin
            r_paid <= w_paid_nxt;
            r_cash <= w_cash_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign paidamt                  = r_paid;
  assign totalcurrency            = r_cash;
  assign storedExcessAmount       = r_excess;
  assign storedInsufficientAmount = r_insuf;
  assign successful               = r_success;
  assign dis                      = r_dis;

endmodule

// File: tb/tb_project1_payment_ctrl.sv
// Directed and random stimulus against a transaction-level reference model of the payment controller.
module tb_project1_payment_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  choice;
  logic [15:0] paymentAmount;
  logic [15:0] ddamt;
  logic [3:0]  currency;
  logic [15:0] paidamt;
  logic [15:0] totalcurrency;
  logic [15:0] storedExcessAmount;
  logic [15:0] storedInsufficientAmount;
  logic        successful;
  logic        dis;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: transaction phase plus the visible totals
  int m_phase;      // 0 waiting for a transaction, 1 collecting, 2 settle cycle
  int m_paid, m_cash, m_exc, m_ins, m_succ, m_dis;
  int m_dd_armed_used;
  int m_prev_note;
  int note_value [16] = '{0, 1, 2, 5, 10, 20, 50, 100, 200, 500, 2000, 0, 0, 0, 0, 0};

  project1_payment_ctrl u_dut (
    .clk                      (clk),
    .rst                      (rst),
    .choice                   (choice),
    .paymentAmount            (paymentAmount),
    .ddamt                    (ddamt),
    .currency                 (currency),
    .paidamt                  (paidamt),
    .totalcurrency            (totalcurrency),
    .storedExcessAmount       (storedExcessAmount),
    .storedInsufficientAmount (storedInsufficientAmount),
    .successful               (successful),
    .dis                      (dis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_edge();
    int c, cc, acc;
    if (rst == 1'b0) begin
      m_phase = 0; m_paid = 0; m_cash = 0; m_exc = 0; m_ins = 0;
      m_succ = 0; m_dis = 0; m_dd_armed_used = 0; m_prev_note = 0;
      return;
    end
    c = 0; cc = 0; acc = 0;
    m_dis = 0;
    if (m_phase != 2) begin
      if (choice == 2'b01 && ddamt != 0 && m_dd_armed_used == 0) begin
        acc = 1; c = int'(ddamt);
      end
      if (choice == 2'b10 && currency != 0 && m_prev_note == 0 && note_value[currency] != 0) begin
        acc = 1; c = note_value[currency]; cc = c;
      end
    end
    m_dd_armed_used = (choice == 2'b01 && (m_dd_armed_used == 1 || acc == 1)) ? 1 : 0;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1 && choice == 2'b11) begin
      if (m_paid >= int'(paymentAmount)) begin
        m_succ = 1; m_dis = 1; m_exc = m_paid - int'(paymentAmount); m_ins = 0;
      end else begin
        m_succ = 0; m_exc = 0; m_ins = int'(paymentAmount) - m_paid;
      end
      m_phase = 2;
    end else if (acc == 1) begin
      if (m_phase == 0) begin
        m_paid = c; m_cash = cc; m_succ = 0; m_exc = 0; m_ins = 0; m_phase = 1;
      end else begin
        m_paid = sat(m_paid + c); m_cash = sat(m_cash + cc);
      end
    end
    m_prev_note = int'(currency);
  endtask

  task automatic cyc(input logic [1:0] ch, input int dd, input int cur, input int due, input logic r);
    choice        = ch;
    ddamt         = 16'(dd);
    currency      = 4'(cur);
    paymentAmount = 16'(due);
    rst           = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("paidamt", int'(paidamt), m_paid);
    chk("totalcurrency", int'(totalcurrency), m_cash);
    chk("excess", int'(storedExcessAmount), m_exc);
    chk("insufficient", int'(storedInsufficientAmount), m_ins);
    chk("successful", int'(successful), m_succ);
    chk("dis", int'(dis), m_dis);
  endtask

  initial begin
    choice = 2'b00; ddamt = '0; currency = '0; paymentAmount = '0; rst = 1'b0;
    m_phase = 0; m_paid = 0; m_cash = 0; m_exc = 0; m_ins = 0;
    m_succ = 0; m_dis = 0; m_dd_armed_used = 0; m_prev_note = 0;

    // Reset with arbitrary inputs, then release
    cyc(2'b01, 1234, 7, 99, 1'b0);
    cyc(2'b10, 55, 3, 99, 1'b0);
    chk("rst_paid", int'(paidamt), 0);
    chk("rst_dis", int'(dis), 0);
    cyc(2'b00, 0, 0, 0, 1'b1);
    cyc(2'b00, 0, 0, 0, 1'b1);
    chk("post_rst_paid", int'(paidamt), 0);

    // One DD per continuous DD_IN assertion
    cyc(2'b01, 0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(2'b01, 500, 0, 0, 1'b1);
    chk("dd_once", int'(paidamt), 500);
    chk("dd_no_cash", int'(totalcurrency), 0);
    cyc(2'b00, 500, 0, 0, 1'b1);
    cyc(2'b01, 500, 0, 0, 1'b1);
    chk("dd_twice", int'(paidamt), 1000);
    cyc(2'b11, 0, 0, 0, 1'b1);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Cash edge detection and invalid code
    cyc(2'b10, 0, 7, 0, 1'b1);
    cyc(2'b10, 0, 0, 0, 1'b1);
    cyc(2'b10, 0, 6, 0, 1'b1);
    cyc(2'b10, 0, 0, 0, 1'b1);
    cyc(2'b10, 0, 12, 0, 1'b1);
    cyc(2'b10, 0, 0, 0, 1'b1);
    chk("cash_total", int'(totalcurrency), 150);
    chk("cash_paid", int'(paidamt), 150);
    for (int i = 0; i < 3; i++) cyc(2'b10, 0, 7, 0, 1'b1);
    cyc(2'b10, 0, 0, 0, 1'b1);
    chk("cash_held", int'(totalcurrency), 250);
    cyc(2'b11, 0, 0, 0, 1'b1);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Exact payment
    cyc(2'b01, 500, 0, 600, 1'b1);
    cyc(2'b00, 0, 0, 600, 1'b1);
    cyc(2'b10, 0, 7, 600, 1'b1);
    cyc(2'b10, 0, 0, 600, 1'b1);
    chk("exact_paid", int'(paidamt), 600);
    cyc(2'b11, 0, 0, 600, 1'b1);
    chk("exact_succ", int'(successful), 1);
    chk("exact_dis", int'(dis), 1);
    chk("exact_excess", int'(storedExcessAmount), 0);
    cyc(2'b11, 0, 0, 600, 1'b1);
    chk("dis_pulse", int'(dis), 0);
    cyc(2'b11, 0, 0, 600, 1'b1);
    chk("idle_settle_dis", int'(dis), 0);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Shortfall
    cyc(2'b01, 700, 0, 1000, 1'b1);
    cyc(2'b11, 0, 0, 1000, 1'b1);
    chk("short_ins", int'(storedInsufficientAmount), 300);
    chk("short_succ", int'(successful), 0);
    chk("short_dis", int'(dis), 0);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Excess
    cyc(2'b10, 0, 10, 100, 1'b1);
    cyc(2'b11, 0, 0, 100, 1'b1);
    chk("excess_amt", int'(storedExcessAmount), 1900);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Saturation, then reset mid-transaction
    cyc(2'b01, 40000, 0, 0, 1'b1);
    cyc(2'b00, 0, 0, 0, 1'b1);
    cyc(2'b01, 40000, 0, 0, 1'b1);
    chk("sat_paid", int'(paidamt), 65535);
    cyc(2'b10, 0, 10, 0, 1'b1);
    cyc(2'b01, 40000, 0, 0, 1'b0);
    chk("midrst_paid", int'(paidamt), 0);
    cyc(2'b00, 0, 0, 0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ch;
      int dd, cur, due;
      logic r;
      ch  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ch = 2'b11;
      case ($urandom_range(0, 3))
        0:       dd = 0;
        1:       dd = int'($urandom_range(30000, 65535));
        default: dd = int'($urandom_range(1, 3000));
      endcase
      cur = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      due = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5000));
      r   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cyc(ch, dd, cur, due, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/project1_payment_ctrl.md
Name: project1_payment_ctrl

Overview:
- Payment-collection controller for the project1 kiosk.
- Accumulates a demand draft (DD) and/or cash notes toward a due amount. On settle it flags success, pulses the dispense output and stores the excess or shortfall.
- Sits between the operator/front-panel inputs and the dispense actuator. Purely synchronous, single clock domain.

Parameters:
- W, 16, width of all amount buses.
- MAX_AMT, 16'hFFFF, saturation ceiling for accumulated amounts.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset: clears state when sampled 0 at a rising clk edge.
- choice  in  2  operation: 00 idle/hold, 01 DD_IN, 10 CASH_IN, 11 SETTLE.
- paymentAmount  in  W  amount due; sampled at settle.
- ddamt  in  W  demand-draft value presented during DD_IN.
- currency  in  4  note code presented during CASH_IN (0 = no note).
- paidamt  out  W  total accepted this transaction (DD + cash).
- totalcurrency  out  W  cash-only portion of paidamt.
- storedExcessAmount  out  W  paid − due after a successful settle.
- storedInsufficientAmount  out  W  due − paid after a failed settle.
- successful  out  1  high from a passing settle until the next transaction starts.
- dis  out  1  dispense pulse, exactly one cycle, on a passing settle.

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0, state IDLE, internal dd_taken=0, prev_currency=0. Reset wins over any choice value, including mid-transaction.
- States: IDLE, COLLECT, SETTLE.
- All outputs are registered. An accepted contribution appears on paidamt one cycle after the accepting edge.
- Transaction start: the first accepted contribution in IDLE.
  - Clears successful, storedExcessAmount and storedInsufficientAmount.
  - Loads paidamt/totalcurrency with the contribution, not an accumulation.
  - Moves to COLLECT.
- DD acceptance (choice==01): accept ddamt when ddamt!=0 and dd_taken==0, then set dd_taken=1. dd_taken clears whenever choice!=01. This gives exactly one DD per continuous DD_IN assertion; holding choice=01 does not re-add.
- Cash acceptance (choice==10):
  - A note is accepted when currency!=0 and prev_currency==0, i.e. one note per 0→nonzero transition. prev_currency registers currency every cycle.
  - Note values: 1→1, 2→2, 3→5, 4→10, 5→20, 6→50, 7→100, 8→200, 9→500, 10→2000.
  - Codes 11–15 are invalid and ignored; totals are unchanged.
  - A cash note adds to both totalcurrency and paidamt. A DD adds to paidamt only.
- Arithmetic: unsigned W-bit adds saturate at MAX_AMT, never wrap.
- choice==00 holds all registers.
- choice==11 in COLLECT → SETTLE (one cycle). At that edge paymentAmount is compared to paidamt:
  - paid ≥ due: successful=1, dis=1 for one cycle, storedExcessAmount = paid − due, storedInsufficientAmount=0.
  - paid < due: successful=0, dis=0, storedInsufficientAmount = due − paid, storedExcessAmount=0.
  - The state then returns to IDLE. paidamt and totalcurrency hold their final values until the next transaction start.
- choice==11 in IDLE is ignored, so a settle without a transaction does nothing.
- A choice change to 11 on the same edge a note or DD would be accepted: the settle takes priority and the contribution is discarded.
- dis never stays high more than one cycle, even if choice is held at 11.

Decomposition:
- Shared package project1_pkg holds:
  - choice encodings (CH_IDLE, CH_DD, CH_CASH, CH_SETTLE);
  - the state enum;
  - W, MAX_AMT;
  - a denomination lookup function (code → value, with a valid flag).
- One natural sub-module, project1_sat_add: W-bit saturating adder, instantiated twice (paidamt and totalcurrency).

Test Plan:
- Reset: drive rst=0 for 2 edges with arbitrary inputs → all outputs 0. Release rst=1 → outputs stay 0 with choice=00.
- Single DD: choice=01, ddamt 0 then 500, held 4 cycles → paidamt=500 (not 2000), totalcurrency=0. Drop choice to 00, then choice=01 again with ddamt=500 → paidamt=1000.
- Cash sequence: choice=10, currency pulses 7,0,6,0,12,0 → totalcurrency=paidamt=150; code 12 is ignored. Currency held at 7 for 3 cycles counts once.
- Successful settle: paymentAmount=600, DD 500 plus note code 7 → paidamt=600. choice=11 → successful=1, dis high exactly 1 cycle, storedExcessAmount=0.
- Shortfall and excess:
  - Due 1000, paid 700 → storedInsufficientAmount=300, successful=0, dis=0.
  - Due 100, paid 2000 → storedExcessAmount=1900.
- Saturation and reset mid-transaction:
  - Repeated DDs of 40000 → paidamt=65535.
  - Asserting rst=0 during COLLECT → all outputs 0 on the next edge.
